// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the four-way round-robin arbiter
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [NREQ-1:0]  req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic req_vec_t idx_to_onehot(input idx_t idx);
        req_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Bit i of the result is the request of client (base + i) mod 4, so position 0 is checked first.
    function automatic req_vec_t rotate_req(input req_vec_t req, input idx_t base);
        req_vec_t rot;
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[idx_t'(base + idx_t'(i))];
        end
        return rot;
    endfunction

endpackage

// File: rtl/rr_arbiter4_prio_enc4.sv
// rtl/rr_arbiter4_prio_enc4.sv - combinational 4-to-2 priority encoder, lowest set bit wins
module prio_enc4
    import arb_pkg::*;
(
    input  req_vec_t in_i,
    output idx_t     idx_o,
    output logic     valid_o
);

    always_comb begin
        valid_o = |in_i;
        idx_o   = '0;
        if (in_i[0]) begin
            idx_o = 2'd0;
        end else if (in_i[1]) begin
            idx_o = 2'd1;
        end else if (in_i[2]) begin
            idx_o = 2'd2;
        end else if (in_i[3]) begin
            idx_o = 2'd3;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter; ARB_TIMEOUT_EN adds a hold-time watchdog
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    arb_state_t state_q, state_d;
    idx_t       owner_q, owner_d;
    idx_t       last_q, last_d;
    req_vec_t   grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       timeout_d;
    logic       grant_change;
    logic       hold_expired;

    req_vec_t   rot_req;
    idx_t       enc_idx;
    logic       enc_valid;
    idx_t       winner;

    // Rotating to start at last+1 leaves the most recent owner at the lowest priority.
    assign rot_req = rotate_req(req, idx_t'(last_q + idx_t'(1)));

    prio_enc4 u_prio_enc4 (
        .in_i    (rot_req),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign winner = idx_t'(last_q + idx_t'(1) + enc_idx);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        timeout_d    = 1'b0;
        grant_change = 1'b0;

        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d      = GRANT;
                    owner_d      = winner;
                    last_d       = winner;
                    grant_d      = idx_to_onehot(winner);
                    busy_d       = 1'b1;
                    grant_change = 1'b1;
                end
            end
            GRANT: begin
                if (req[owner_q] && !hold_expired) begin
                    state_d = GRANT;
                end else if (enc_valid) begin
                    // Owner is last in rotated order, so a revoked owner cannot win here.
                    state_d      = GRANT;
                    owner_d      = winner;
                    last_d       = winner;
                    grant_d      = idx_to_onehot(winner);
                    busy_d       = 1'b1;
                    grant_change = 1'b1;
                    timeout_d    = req[owner_q];
                end else begin
                    state_d      = IDLE;
                    owner_d      = '0;
                    grant_d      = '0;
                    busy_d       = 1'b0;
                    grant_change = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                owner_d      = '0;
                grant_d      = '0;
                busy_d       = 1'b0;
                grant_change = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= idx_t'(3);
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q;

    assign hold_expired = (hold_cnt_q == HOLD_W'(MAX_HOLD)) && (|(req & ~grant_q));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (grant_change || (state_q == IDLE)) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic       unused_timeout_d;
    logic       unused_grant_change;
    logic [7:0] unused_max_hold;

    assign hold_expired        = 1'b0;
    assign unused_timeout_d    = timeout_d;
    assign unused_grant_change = grant_change;
    assign unused_max_hold     = 8'(MAX_HOLD);
    assign timeout             = 1'b0;
`endif

    assign grant     = grant_q;
    assign grant_idx = owner_q;
    assign busy      = busy_q;

endmodule
